// File: rtl/clk_div_prog.sv
// clk_div_prog: run-time programmable integer clock divider.
//   Produces clk_out with a period of exactly N clk_in cycles (N >= 2), a
//   one-cycle tick at the start of each high phase, and glitch-free ratio
//   changes. A new divisor is held pending and only takes effect at the next
//   period boundary, or on the next edge when the divider is idle.
//
// Optional build macro: CLK_DIV_ODD_DUTY50_EN
//   When defined, odd N gets an exact 50% duty cycle. A negedge flop
//   stretches a shortened posedge high window by half a clk_in cycle.
//
// Ports:
//   clk_in    source clock
//   rst_n     asynchronous active-low reset
//   en        run request (level); a stop only takes effect at the period wrap
//   div_val   new divisor N, clamped to >= 2
//   div_load  single-cycle load qualifier, accepted only while busy is low
//   busy      a loaded divisor is pending
//   div_ack   one-cycle pulse on the cycle the new divisor takes effect
//   clk_out   divided clock
//   tick      one-cycle pulse on the first clk_in cycle of each high phase
//   running   high while the divider is in RUN
module clk_div_prog #(
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned DIV_DEFAULT = 27
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             busy,
    output logic             div_ack,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    localparam logic [WIDTH-1:0] DIV_RST =
        (DIV_DEFAULT < 2) ? WIDTH'(2) : WIDTH'(DIV_DEFAULT);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] pend_q;
    logic             busy_q;
    logic             ack_q;
    logic             pos_q;
    logic             tick_q;
    logic             run_q;

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] hi_lim_c;
    logic             wrap_c;
    logic             load_ok_c;
    logic             apply_c;

    // Divisors below 2 cannot produce a toggling output.
    function automatic logic [WIDTH-1:0] clamp2(input logic [WIDTH-1:0] v);
        return (v < WIDTH'(2)) ? WIDTH'(2) : v;
    endfunction

    // Period bookkeeping; div_q is only ever replaced at a wrap or in IDLE,
    // so the compare below never sees a divisor change mid-period.
    always_comb begin
        cnt_d     = cnt_q + WIDTH'(1);
        wrap_c    = (cnt_q == (div_q - WIDTH'(1)));
        load_ok_c = div_load & ~busy_q;
        apply_c   = busy_q & ((state_q == IDLE) | wrap_c);
`ifdef CLK_DIV_ODD_DUTY50_EN
        // floor(N/2): the negedge flop adds the missing half cycle for odd N.
        hi_lim_c  = div_q >> 1;
`else
        // ceil(N/2) without overflowing at the top of the range.
        hi_lim_c  = (div_q >> 1) + {{(WIDTH-1){1'b0}}, div_q[0]};
`endif
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_RST;
            pend_q  <= DIV_RST;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            pos_q   <= 1'b0;
            tick_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            ack_q  <= 1'b0;

            // load_ok_c and apply_c are exclusive: one needs busy low, the other high.
            if (load_ok_c) begin
                pend_q <= clamp2(div_val);
                busy_q <= 1'b1;
            end
            if (apply_c) begin
                div_q  <= pend_q;
                busy_q <= 1'b0;
                ack_q  <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (en) begin
                        state_q <= RUN;
                        pos_q   <= 1'b1;
                        tick_q  <= 1'b1;
                        run_q   <= 1'b1;
                    end else begin
                        pos_q   <= 1'b0;
                    end
                end
                RUN: begin
                    if (wrap_c) begin
                        cnt_q <= '0;
                        if (en) begin
                            pos_q  <= 1'b1;
                            tick_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            pos_q   <= 1'b0;
                            run_q   <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        pos_q <= (cnt_d < hi_lim_c);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic neg_q;

    // Half-cycle extension of the high window, only for odd divisors.
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q & div_q[0];
        end
    end

    assign clk_out = pos_q | neg_q;
`else
    assign clk_out = pos_q;
`endif

    assign busy    = busy_q;
    assign div_ack = ack_q;
    assign tick    = tick_q;
    assign running = run_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: scoreboard bench for clk_div_prog (default parameters).
//   Stimulus pushes expected tick cycles, div_ack cycles and clk_out
//   high-phase lengths (in half clk_in cycles); monitors pop and compare.
module tb_clk_div_prog;

    localparam int unsigned WIDTH = 24;

    logic             clk_in;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] div_val;
    logic             div_load;
    logic             busy;
    logic             div_ack;
    logic             clk_out;
    logic             tick;
    logic             running;

    clk_div_prog #(.WIDTH(WIDTH), .DIV_DEFAULT(27)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .busy     (busy),
        .div_ack  (div_ack),
        .clk_out  (clk_out),
        .tick     (tick),
        .running  (running)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int tick_exp[$];
    int ack_exp[$];
    int hi_exp[$];

    int hi_cnt  = 0;
    bit hi_prev = 1'b0;

    int t0, t1, t2, t3, t4, t5, t6;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm, input int where);
        total++;
        bad++;
        $display("FAIL %s: unexpected event at cycle %0d", nm, where);
    endtask

    // Expected clk_out high time in half clk_in cycles.
    function automatic int hi_halves(input int n);
`ifdef CLK_DIV_ODD_DUTY50_EN
        return n;
`else
        return n + (n % 2);
`endif
    endfunction

    task automatic push_period(input int t, input int n);
        tick_exp.push_back(t);
        hi_exp.push_back(hi_halves(n));
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk_in);
        if (cyc != c) fail("schedule", cyc);
    endtask

    // Half-cycle clk_out sampler: measures each high phase on its fall.
    task automatic half_sample();
        if (clk_out === 1'b1) begin
            hi_cnt++;
        end else begin
            if (hi_prev) begin
                if (hi_exp.size() == 0) fail("hi_spurious", cyc);
                else chk("hi_len", hi_cnt, hi_exp.pop_front());
            end
            hi_cnt = 0;
        end
        hi_prev = (clk_out === 1'b1);
    endtask

    always @(posedge clk_in) cyc = cyc + 1;

    // Pulse monitor.
    always @(posedge clk_in) begin
        #1;
        if (tick === 1'b1) begin
            if (tick_exp.size() == 0) fail("tick_spurious", cyc);
            else chk("tick_cycle", cyc, tick_exp.pop_front());
        end
        if (div_ack === 1'b1) begin
            if (ack_exp.size() == 0) fail("ack_spurious", cyc);
            else chk("ack_cycle", cyc, ack_exp.pop_front());
        end
        half_sample();
    end

    always @(negedge clk_in) begin
        #1;
        half_sample();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        repeat (2) @(negedge clk_in);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick",    tick,    0);
        chk("rst_busy",    busy,    0);
        chk("rst_div_ack", div_ack, 0);
        chk("rst_running", running, 0);
        rst_n = 1'b1;

        // Default divisor 27, immediate rise from IDLE.
        @(negedge clk_in);
        t0 = cyc + 1;
        en = 1'b1;
        push_period(t0, 27);
        push_period(t0 + 27, 27);
        wait_cyc(t0 + 1);
        chk("run_on",   running, 1);
        chk("rise_now", clk_out, 1);

        // Load 4 at cnt=5; takes effect at the wrap.
        wait_cyc(t0 + 32);
        div_val  = WIDTH'(4);
        div_load = 1'b1;
        t1 = t0 + 54;
        ack_exp.push_back(t1);
        push_period(t1, 4);
        @(negedge clk_in);
        div_load = 1'b0;
        chk("busy_load4", busy, 1);
        wait_cyc(t0 + 53);
        chk("busy_hold", busy, 1);
        wait_cyc(t0 + 54);
        chk("busy_clear", busy, 0);

        // Load 10 while running at N=4.
        wait_cyc(t1 + 1);
        div_val  = WIDTH'(10);
        div_load = 1'b1;
        t2 = t1 + 4;
        ack_exp.push_back(t2);
        push_period(t2, 10);
        @(negedge clk_in);
        div_load = 1'b0;

        // Drop en at cnt=3: period completes, then IDLE.
        wait_cyc(t2 + 3);
        en = 1'b0;
        wait_cyc(t2 + 4);
        chk("stop_hi_cnt4", clk_out, 1);
        wait_cyc(t2 + 5);
        chk("stop_lo_cnt5", clk_out, 0);
        wait_cyc(t2 + 9);
        chk("stop_run_late", running, 1);
        wait_cyc(t2 + 10);
        chk("stop_run_off", running, 0);
        chk("stop_clk_lo",  clk_out, 0);
        wait_cyc(t2 + 12);
        en = 1'b1;
        t3 = t2 + 13;
        push_period(t3, 10);
        wait_cyc(t3);
        chk("rerise", clk_out, 1);
        wait_cyc(t3 + 2);
        en = 1'b0;

        // Clamped loads in IDLE; busy load ignored; load on ack cycle accepted.
        wait_cyc(t3 + 12);
        div_val  = '0;
        div_load = 1'b1;
        ack_exp.push_back(t3 + 14);
        wait_cyc(t3 + 13);
        chk("busy_idle_load", busy, 1);
        div_val = WIDTH'(1);
        wait_cyc(t3 + 14);
        chk("busy_idle_ack", busy, 0);
        ack_exp.push_back(t3 + 16);
        wait_cyc(t3 + 15);
        div_load = 1'b0;
        chk("busy_ack_cycle_load", busy, 1);
        wait_cyc(t3 + 16);
        chk("busy_idle_done", busy, 0);

        // Run at N=2, then switch to N=5.
        wait_cyc(t3 + 18);
        en = 1'b1;
        t4 = t3 + 19;
        push_period(t4, 2);
        wait_cyc(t4);
        div_val  = WIDTH'(5);
        div_load = 1'b1;
        ack_exp.push_back(t4 + 2);
        push_period(t4 + 2, 5);
        wait_cyc(t4 + 1);
        div_load = 1'b0;
        t5 = t4 + 7;
        tick_exp.push_back(t5);
        hi_exp.push_back(4);

        // Async reset mid high phase with a load pending.
        wait_cyc(t5);
        div_val  = WIDTH'(8);
        div_load = 1'b1;
        wait_cyc(t5 + 1);
        div_load = 1'b0;
        chk("pre_rst_clk", clk_out, 1);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_clk",  clk_out, 0);
        chk("mid_rst_busy", busy,    0);
        chk("mid_rst_run",  running, 0);
        chk("mid_rst_ack",  div_ack, 0);
        en = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;

        // Period back to the default after reset.
        @(negedge clk_in);
        t6 = cyc + 1;
        en = 1'b1;
        push_period(t6, 27);
        push_period(t6 + 27, 27);
        wait_cyc(t6 + 30);
        en = 1'b0;
        wait_cyc(t6 + 60);
        chk("end_running", running, 0);
        chk("tick_left", tick_exp.size(), 0);
        chk("ack_left",  ack_exp.size(),  0);
        chk("hi_left",   hi_exp.size(),   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
